// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, reset PC, opcodes and
// instruction field positions used by the fetch unit and its PC logic.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    EXEC        = 2'd2,
    HALT        = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 26;
  localparam int FUNCT_MSB   = 5;
  localparam int FUNCT_LSB   = 0;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;
  localparam int JTARGET_MSB = 25;
  localparam int JTARGET_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Sign-extended 16-bit immediate, already scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [31:0] instr);
    return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC target computation and priority select (Jump > taken Branch > PC+4).
// Purely combinational so a pipelined fetch can reuse it unchanged.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic        w_unused;

  assign w_jump_target   = {pc_plus4[31:28], instr[JTARGET_MSB:JTARGET_LSB], 2'b00};
  assign w_branch_target = pc_plus4 + branch_offset(instr);
  assign w_unused        = ^instr[OP_MSB:OP_LSB];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = w_jump_target;
    end else if (branch && zero) begin
      next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake, holds
// each instruction for one execute window and counts retired instructions.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  output logic [31:0]      Instr,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             Jump,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYC);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic             r_run;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [9:0]       r_timer;
  logic             r_fetch_err;
  logic [CNT_W-1:0] r_retired;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;
  logic [9:0]       w_timer_next;
  logic             w_fetching;
  logic             w_ack_take;
  logic             w_commit;
  logic             w_timeout;

  // r_run stays low for the first edge after reset release, so the request
  // only rises once reset is synchronously released and any ack left over
  // from before the reset is ignored.
  assign w_fetching   = r_run && ((r_state == FETCH_ISSUE) || (r_state == FETCH_WAIT));
  assign w_ack_take   = w_fetching && imem_ack;
  assign w_commit     = (r_state == EXEC) && !stall;
  assign w_timer_next = (r_state == FETCH_WAIT) ? (r_timer + 10'd1) : 10'd0;
  assign w_timeout    = r_run && (r_state == FETCH_WAIT) && !imem_ack &&
                        (w_timer_next == TIMEOUT_LIM);
  assign w_pc_plus4   = r_pc + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .branch   (Branch),
    .zero     (Zero),
    .jump     (Jump),
    .next_pc  (w_next_pc)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FETCH_ISSUE: begin
        if (r_run) begin
          w_state_next = imem_ack ? EXEC : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          w_state_next = EXEC;
        end else if (w_timeout) begin
          w_state_next = HALT;
        end
      end
      EXEC: begin
        if (!stall) begin
          w_state_next = FETCH_ISSUE;
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = FETCH_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH_ISSUE;
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0000_0000;
      r_timer     <= 10'd0;
      r_fetch_err <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (w_ack_take) begin
        r_instr <= imem_rdata;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
      if (w_commit) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign imem_req    = w_fetching;
  assign imem_addr   = r_pc;
  assign Instr       = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign instr_valid = (r_state == EXEC);
  assign fetch_err   = r_fetch_err;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: three instances with different
// reset PCs share the stimulus; only the selected one is out of reset.
module tb_instr_fetch_unit;

  localparam int unsigned TMO = 8;
  localparam logic [2:0][31:0] RPCS = {32'hFFFF_FFFC, 32'h4000_0020, 32'h0000_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             stall, branch, zero, jump;
  logic [2:0]       req_o, valid_o, err_o;
  logic [2:0][31:0] addr_o, instr_o, pc_o, pc4_o, ret_o;
  logic [1:0]       sel;

  logic        o_req, o_valid, o_err;
  logic [31:0] o_addr, o_instr, o_pc, o_pc4, o_ret;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_commits = 0;
  logic [31:0] fetch_addr;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    instr_fetch_unit #(
      .RESET_PC    (RPCS[gi]),
      .TIMEOUT_CYC (TMO),
      .CNT_W       (32)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n[gi]),
      .imem_req    (req_o[gi]),
      .imem_addr   (addr_o[gi]),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .Instr       (instr_o[gi]),
      .PC          (pc_o[gi]),
      .PCPlus4     (pc4_o[gi]),
      .instr_valid (valid_o[gi]),
      .stall       (stall),
      .Branch      (branch),
      .Zero        (zero),
      .Jump        (jump),
      .fetch_err   (err_o[gi]),
      .retired     (ret_o[gi])
    );
  end

  assign o_req   = req_o[sel];
  assign o_valid = valid_o[sel];
  assign o_err   = err_o[sel];
  assign o_addr  = addr_o[sel];
  assign o_instr = instr_o[sel];
  assign o_pc    = pc_o[sel];
  assign o_pc4   = pc4_o[sel];
  assign o_ret   = ret_o[sel];

  // Wait (bounded) for a request, hold it lat cycles, then ack for one cycle.
  task automatic fetch(input logic [31:0] data, input int lat);
    int n = 0;
    while (!o_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (o_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_req_wait: imem_req=%b after %0d cycles, required 1", o_req, n);
    end
    fetch_addr = o_addr;
    repeat (lat) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    $display("fetch dut=%0d addr=%h instr=%h lat=%0d", sel, fetch_addr, data, lat);
  endtask

  task automatic commit(input logic b, input logic z, input logic j);
    branch = b;
    zero   = z;
    jump   = j;
    stall  = 1'b0;
    @(negedge clk);
    branch = 1'b0;
    zero   = 1'b0;
    jump   = 1'b0;
    n_commits++;
    $display("commit dut=%0d branch=%b zero=%b jump=%b next_addr=%h", sel, b, z, j, o_addr);
  endtask

  task automatic test_reset();
    sel = 2'd0;
    @(negedge clk);
    n_assert++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b need 0", o_req); end
    n_assert++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h need 0", o_pc); end
    n_assert++; if (o_pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h need 4", o_pc4); end
    n_assert++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h need 0", o_instr); end
    n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b need 0", o_valid); end
    n_assert++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b need 0", o_err); end
    n_assert++; if (o_ret !== 32'h0) begin n_fail++; $display("FAIL rst_retired: got %0d need 0", o_ret); end
    $display("reset checked dut=0");
    rst_n[0] = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0, 1);
      n_assert++; if (fetch_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr%0d: got %h need %h", i, fetch_addr, 32'(i * 4)); end
      n_assert++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b need 1", i, o_valid); end
      commit(1'b0, 1'b0, 1'b0);
      n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_drop%0d: got %b need 0", i, o_valid); end
      n_assert++; if (o_pc !== 32'((i + 1) * 4)) begin n_fail++; $display("FAIL seq_pc%0d: got %h need %h", i, o_pc, 32'((i + 1) * 4)); end
    end
    n_assert++; if (o_ret !== 32'd3) begin n_fail++; $display("FAIL seq_retired: got %0d need 3", o_ret); end
  endtask

  task automatic test_branch();
    fetch(32'h0, 1);
    commit(1'b0, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 1);
    n_assert++; if (fetch_addr !== 32'h10) begin n_fail++; $display("FAIL br_addr: got %h need 10", fetch_addr); end
    n_assert++; if (o_instr !== 32'h1000_FFFE) begin n_fail++; $display("FAIL br_instr: got %h need 1000fffe", o_instr); end
    n_assert++; if (o_pc4 !== 32'h14) begin n_fail++; $display("FAIL br_pc4: got %h need 14", o_pc4); end
    commit(1'b1, 1'b1, 1'b0);
    n_assert++; if (o_addr !== 32'h0C) begin n_fail++; $display("FAIL br_taken: got %h need 0c", o_addr); end
    fetch(32'h0, 1);
    commit(1'b0, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 1);
    commit(1'b1, 1'b0, 1'b0);
    n_assert++; if (o_addr !== 32'h14) begin n_fail++; $display("FAIL br_not_taken: got %h need 14", o_addr); end
  endtask

  task automatic test_min_latency();
    fetch(32'hABCD_0123, 0);
    n_assert++; if (fetch_addr !== 32'h14) begin n_fail++; $display("FAIL lat0_addr: got %h need 14", fetch_addr); end
    n_assert++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lat0_valid: got %b need 1", o_valid); end
    n_assert++; if (o_instr !== 32'hABCD_0123) begin n_fail++; $display("FAIL lat0_instr: got %h need abcd0123", o_instr); end
    commit(1'b0, 1'b0, 1'b0);
    n_assert++; if (o_addr !== 32'h18) begin n_fail++; $display("FAIL lat0_next: got %h need 18", o_addr); end
  endtask

  task automatic test_stall();
    fetch(32'h2001_0005, 1);
    stall  = 1'b1;
    branch = 1'b1;
    zero   = 1'b1;
    jump   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_assert++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %b need 1", k, o_valid); end
      n_assert++; if (o_instr !== 32'h2001_0005) begin n_fail++; $display("FAIL stall_instr%0d: got %h need 20010005", k, o_instr); end
      n_assert++; if (o_pc !== 32'h18) begin n_fail++; $display("FAIL stall_pc%0d: got %h need 18", k, o_pc); end
      n_assert++; if (o_ret !== 32'(n_commits)) begin n_fail++; $display("FAIL stall_retired%0d: got %0d need %0d", k, o_ret, n_commits); end
    end
    commit(1'b0, 1'b0, 1'b0);
    n_assert++; if (o_ret !== 32'(n_commits)) begin n_fail++; $display("FAIL stall_release_retired: got %0d need %0d", o_ret, n_commits); end
    n_assert++; if (o_pc !== 32'h1C) begin n_fail++; $display("FAIL stall_release_pc: got %h need 1c", o_pc); end
    n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b need 0", o_valid); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    while (!o_err && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    $display("timeout dut=0 fetch_err after %0d cycles", cnt);
    n_assert++; if (cnt != int'(TMO) + 1) begin n_fail++; $display("FAIL tmo_cycles: got %0d need %0d", cnt, TMO + 1); end
    n_assert++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL tmo_req: got %b need 0", o_req); end
    n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_valid: got %b need 0", o_valid); end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    @(negedge clk);
    n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack_valid: got %b need 0", o_valid); end
    n_assert++; if (o_instr !== 32'h2001_0005) begin n_fail++; $display("FAIL late_ack_instr: got %h need 20010005", o_instr); end
    n_assert++; if (o_pc !== 32'h1C) begin n_fail++; $display("FAIL halt_pc: got %h need 1c", o_pc); end
    n_assert++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL halt_err: got %b need 1", o_err); end
    #2 rst_n[0] = 1'b0;
    #1;
    n_assert++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL tmo_rst_pc: got %h need 0", o_pc); end
    n_assert++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL tmo_rst_err: got %b need 0", o_err); end
    n_assert++; if (o_ret !== 32'h0) begin n_fail++; $display("FAIL tmo_rst_retired: got %0d need 0", o_ret); end
  endtask

  task automatic test_jump();
    sel = 2'd1;
    @(negedge clk);
    rst_n[1] = 1'b1;
    fetch(32'h0800_0100, 1);
    n_assert++; if (fetch_addr !== 32'h4000_0020) begin n_fail++; $display("FAIL jmp_addr: got %h need 40000020", fetch_addr); end
    n_assert++; if (o_pc4 !== 32'h4000_0024) begin n_fail++; $display("FAIL jmp_pc4: got %h need 40000024", o_pc4); end
    commit(1'b1, 1'b1, 1'b1);
    n_assert++; if (o_addr !== 32'h4000_0400) begin n_fail++; $display("FAIL jmp_target: got %h need 40000400", o_addr); end
    n_assert++; if (o_ret !== 32'd1) begin n_fail++; $display("FAIL jmp_retired: got %0d need 1", o_ret); end
    rst_n[1] = 1'b0;
  endtask

  task automatic test_wrap_reset();
    sel = 2'd2;
    @(negedge clk);
    rst_n[2] = 1'b1;
    fetch(32'h0, 1);
    n_assert++; if (fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h need fffffffc", fetch_addr); end
    n_assert++; if (o_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h need 0", o_pc4); end
    commit(1'b0, 1'b0, 1'b0);
    n_assert++; if (o_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h need 0", o_addr); end
    @(negedge clk);
    n_assert++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: got %b need 1", o_req); end
    #2 rst_n[2] = 1'b0;
    #1;
    n_assert++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b need 0", o_req); end
    n_assert++; if (o_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL midrst_addr: got %h need fffffffc", o_addr); end
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    rst_n[2]   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stale_ack_valid: got %b need 0", o_valid); end
    n_assert++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL fresh_req: got %b need 1", o_req); end
    fetch(32'h0000_0020, 1);
    n_assert++; if (fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL refetch_addr: got %h need fffffffc", fetch_addr); end
    n_assert++; if (o_instr !== 32'h0000_0020) begin n_fail++; $display("FAIL refetch_instr: got %h need 00000020", o_instr); end
    n_assert++; if (o_ret !== 32'h0) begin n_fail++; $display("FAIL refetch_retired: got %0d need 0", o_ret); end
  endtask

  initial begin
    rst_n      = 3'b000;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    sel        = 2'd0;
    test_reset();
    test_sequential();
    test_branch();
    test_min_latency();
    test_stall();
    test_timeout();
    test_jump();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the opcode/funct decoder in the MIPS core.
- Holds the PC and fetches 32-bit instructions over a variable-latency instruction-memory handshake.
- Presents each instruction, with PC and PC+4, to the decoder and datapath for exactly one execute window.
- Computes next PC from Branch/Zero/Jump fed back from the control unit and ALU; adds fetch-timeout error and retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned)
TIMEOUT_CYC, 255, max cycles waiting for imem_ack before error (1..1023)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising-edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  word-aligned fetch address (= PC)
imem_rdata  in  32  instruction data, valid when imem_ack=1
imem_ack  in  1  one-cycle acknowledge from instruction memory
Instr  out  32  current instruction; Opcode=Instr[31:26], Funct=Instr[5:0] feed the decoder
PC  out  32  address of Instr
PCPlus4  out  32  PC+4
instr_valid  out  1  Instr is in execute window; datapath commits only when instr_valid=1 and stall=0
stall  in  1  datapath hold request (e.g. data-memory busy)
Branch  in  1  from control unit
Zero  in  1  from ALU
Jump  in  1  from control unit
fetch_err  out  1  sticky: imem timeout occurred
retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (async assert, sync-released internally by clk edge): PC=RESET_PC, Instr=32'h0000_0000 (nop), instr_valid=0, imem_req=0, fetch_err=0, retired=0, state=FETCH_ISSUE.
- States: FETCH_ISSUE, FETCH_WAIT, EXEC, HALT.
- FETCH_ISSUE: imem_req=1, imem_addr=PC, timer=0 -> FETCH_WAIT next cycle.
- FETCH_WAIT: imem_req held 1, imem_addr stable. On imem_ack: Instr<=imem_rdata, imem_req<=0 -> EXEC. Else timer++; timer reaching TIMEOUT_CYC -> fetch_err<=1, imem_req<=0 -> HALT.
- Ack arriving in FETCH_ISSUE cycle itself is accepted identically (minimum fetch latency 1 cycle: issue -> EXEC after 2 edges).
- EXEC: instr_valid=1 (combinational on state). If stall=1: hold everything, no counter change. If stall=0, at clock edge:
  - PC<=next_pc, retired<=retired+1 (wraps at 2^CNT_W-1 -> 0), -> FETCH_ISSUE.
- next_pc priority: Jump=1 -> {PCPlus4[31:28], Instr[25:0], 2'b00}; else Branch&Zero -> PCPlus4 + (sign_ext(Instr[15:0])<<2); else PCPlus4. Jump and Branch both high: Jump wins.
- All PC arithmetic modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
- Branch/Jump/Zero sampled only in EXEC with stall=0; ignored in all other states.
- imem_ack outside FETCH_ISSUE/FETCH_WAIT: ignored, no state change.
- HALT: instr_valid=0, imem_req=0, PC frozen; exit only by reset.
- Reset mid-fetch: imem_req drops immediately (async); outstanding ack after release is ignored because state restarts at FETCH_ISSUE with fresh request.
- PCPlus4 always = PC+4 combinationally.

Decomposition:
- Shared package mips_pkg: opcode constants, fetch state enum (FETCH_ISSUE/FETCH_WAIT/EXEC/HALT), RESET_PC default, instruction field slice constants (OP_MSB/LSB, IMM, JTARGET).
- One sub-module: next_pc_logic (combinational target/priority mux), reusable by a later pipelined fetch.

Test Plan:
- Reset, imem acks 1 cycle after every req with sequential nops, stall=0 -> imem_addr sequence 0x0,0x4,0x8; retired=3 after third EXEC; instr_valid pulses 1 cycle per instruction.
- At PC=0x10, Instr=32'h1000_FFFE (beq, imm=-2), Branch=1, Zero=1 -> next imem_addr=0x0C; same with Zero=0 -> 0x14.
- At PC=0x4000_0020, Instr=32'h0800_0100, Jump=1, Branch=1, Zero=1 -> next imem_addr=0x4000_0400 (Jump priority).
- Stall=1 for 5 cycles in EXEC -> Instr, PC, retired unchanged, instr_valid stays 1; stall drop -> single commit, retired+1.
- No ack for TIMEOUT_CYC cycles -> fetch_err=1, imem_req=0, instr_valid=0 held; late ack ignored; rst_n low restores PC=RESET_PC, fetch_err=0.
- RESET_PC=32'hFFFF_FFFC, sequential fetch -> second imem_addr=0x0000_0000; rst_n asserted mid FETCH_WAIT -> imem_req=0 same cycle.
